// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the TX arbiter.
package uart_pkg;

  // One requester per core in the dual-core SoC.
  localparam int unsigned UART_ARB_NUM_REQ = 2;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } uart_arb_state_e;

endpackage

// File: rtl/uart_arb_rr_sel.sv
// Combinational round-robin picker: returns the first requesting index
// found when scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
module uart_arb_rr_sel
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = UART_ARB_NUM_REQ,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  logic [IDX_W-1:0] cand;

  // Scan starts just after the last served index so it ends up lowest priority.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_i) + k) % NUM_REQ);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO push port between NUM_REQ byte streams.
// A winner keeps the port until it pushes a byte flagged last, so
// messages from different requesters never interleave.
// Optional feature macro: UART_ARB_TIMEOUT_EN (forced release of an idle lock).
//
// state      | meaning
// -----------+------------------------------------------------------------
// ARB_IDLE   | no owner; outputs quiet; arbitrate among valid requesters
// ARB_LOCKED | owner_q passes straight through to the FIFO until last/flush
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = UART_ARB_NUM_REQ,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      fifo_valid_o,
  output logic [DATA_W-1:0]         fifo_data_o,
  input  logic                      fifo_ready_i,
  input  logic                      flush_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  uart_arb_state_e  state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             busy;
  logic             owner_valid;
  logic             owner_last;
  logic             xfer;
  logic             timeout;

  uart_arb_rr_sel #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_sel (
    .req_i    (req_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  assign busy        = (state_q == ARB_LOCKED);
  assign owner_valid = req_valid_i[owner_q];
  assign owner_last  = req_last_i[owner_q];
  assign xfer        = fifo_valid_o & fifo_ready_i;

  // Passthrough from the owner while locked; data forced to zero when not valid.
  always_comb begin
    fifo_valid_o = 1'b0;
    fifo_data_o  = '0;
    req_ready_o  = '0;
    if (busy) begin
      fifo_valid_o         = owner_valid;
      req_ready_o[owner_q] = fifo_ready_i;
      if (owner_valid) begin
        fifo_data_o = req_data_i[owner_q*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_o   = busy ? (NUM_REQ'(1) << owner_q) : '0;
  assign busy_o    = busy;
  assign timeout_o = timeout;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  // Idle counter register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Count only cycles where the owner has nothing to offer; a FIFO stall
  // with the owner valid is not idleness.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    timeout    = 1'b0;
    if (!busy || xfer) begin
      idle_cnt_d = '0;
    end else if (!owner_valid) begin
      if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout    = 1'b1;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state: flush beats a new grant; release records the owner as last served.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (!flush_i && pick_found) begin
          state_d = ARB_LOCKED;
          owner_d = pick_idx;
        end
      end
      ARB_LOCKED: begin
        if (flush_i || (xfer && owner_last) || timeout) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = owner_q;
        end
      end
    endcase
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART TX FIFO write port between NUM_REQ byte-stream requesters (one per core in the dual-core SoC) with round-robin arbitration and message atomicity. A requester that wins the grant owns the FIFO until it sends a byte flagged last, so log lines from different cores are never interleaved. Sits between the per-core TX request streams and the TX FIFO push interface of the UART, beside the register block.

## Interface
- NUM_REQ, 2, number of requesters (≥2)
- DATA_W, 8, byte width, fixed to the TX_DATA field width
- TIMEOUT_CYCLES, 1024, idle cycles before a held lock is forcibly released (used only with UART_ARB_TIMEOUT_EN)

- clk_i  in  1  system clock
- arst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester byte valid
- req_data_i  in  NUM_REQ*DATA_W  per-requester byte, requester i at [i*DATA_W +: DATA_W]
- req_last_i  in  NUM_REQ  byte is the final byte of the message
- req_ready_o  out  NUM_REQ  per-requester byte accepted
- fifo_valid_o  out  1  push request to TX FIFO
- fifo_data_o  out  DATA_W  byte pushed to TX FIFO
- fifo_ready_i  in  1  TX FIFO not full
- flush_i  in  1  TX_FIFO_FLUSH pulse from CTRL; aborts current lock
- grant_o  out  NUM_REQ  one-hot current owner, zero when idle
- busy_o  out  1  lock held
- timeout_o  out  1  one-cycle pulse on forced release

## Operation
- Two states: IDLE, LOCKED. Registers: state, owner index, rr_ptr (last served index), idle counter.
- IDLE: no passthrough; all req_ready_o = 0, fifo_valid_o = 0. If any req_valid_i, pick first set index scanning rr_ptr+1, rr_ptr+2, … mod NUM_REQ; register owner, go LOCKED.
- LOCKED: combinational passthrough from owner: fifo_valid_o = req_valid_i[owner], fifo_data_o = owner's byte, req_ready_o[owner] = fifo_ready_i; all other ready = 0.
- Transfer = fifo_valid_o & fifo_ready_i. Transfer with req_last_i[owner] = 1 → IDLE, rr_ptr ← owner.
- flush_i = 1 in any state → IDLE next cycle, rr_ptr ← owner if LOCKED; a transfer in the same cycle still completes. flush_i has priority over a new grant in IDLE.
- Non-owner requesters held off (ready 0) for any lock duration; they must keep data stable while valid (AXI-stream rule).
- fifo_data_o is driven to 0 whenever fifo_valid_o = 0.
- grant_o = onehot(owner) & {NUM_REQ{busy_o}}; busy_o = (state == LOCKED).

## Timing
- Reset: state IDLE, rr_ptr = NUM_REQ-1 (requester 0 wins first), owner 0, counter 0; all outputs 0.
- Arbitration latency: valid rises in cycle 0 in IDLE → grant_o/busy_o in cycle 1 → first transfer possible in cycle 1.
- Throughput in LOCKED: one byte per cycle while owner valid and fifo_ready_i.
- Release: last-byte transfer in cycle n → IDLE in n+1 → next grant registered at end of n+1, visible in n+2. One dead cycle between messages.
- Single-byte message (last on first byte): owner holds exactly one cycle if FIFO ready.
- FIFO full (fifo_ready_i = 0): lock held, no transfer, no timeout counting (stall is not idleness).
- Reset asserted mid-message: immediate IDLE, partial message abandoned; requester must restart.

## Configuration
- UART_ARB_TIMEOUT_EN defined: in LOCKED, counter increments each cycle req_valid_i[owner] = 0, clears on any transfer or entry to LOCKED; at count TIMEOUT_CYCLES-1 → IDLE next cycle, rr_ptr ← owner, timeout_o pulses for that one cycle. Counter width $clog2(TIMEOUT_CYCLES)+1.
- Not defined: no counter; lock held until last or flush; timeout_o tied 0; TIMEOUT_CYCLES ignored.

## Structure
- uart_pkg gains: UART_ARB_NUM_REQ localparam (2), uart_arb_state_e enum {ARB_IDLE, ARB_LOCKED}.
- One sub-module: uart_arb_rr_sel — combinational round-robin picker (req vector, rr_ptr → index, found).

## Test plan
- Reset then req 0 sends 3 bytes 0x41,0x42,0x0A(last) → grant_o = 01 cycle 1, FIFO receives 41,42,0A on cycles 1–3, busy_o low cycle 4.
- Both requesters valid simultaneously from reset, each a 2-byte message → order req0 message, then req1 message; no interleaving; rr_ptr = 1 after.
- Owner mid-message, fifo_ready_i low 5 cycles → no transfers, req_ready_o all 0, lock held, resume with correct next byte.
- flush_i pulsed while req1 owns after 1 of 4 bytes → IDLE next cycle, req0 (waiting) granted the following cycle.
- UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16: owner sends 1 byte then drops valid → timeout_o pulse exactly 16 cycles after last transfer, lock released, other requester granted next cycle.
